// File: rtl/jtag_vio_pkg.sv
// jtag_vio_pkg: shared types and helpers for the JTAG probe source.
// Holds the access-state encoding and the bit-counter width rule.
package jtag_vio_pkg;

    typedef enum logic [1:0] {
        VIO_IDLE    = 2'd0,
        VIO_CAPTURE = 2'd1,
        VIO_SHIFT   = 2'd2
    } vio_state_t;

    // Counter must hold 0..width+1 so an over-length shift stays detectable.
    function automatic int vio_cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/jtag_vio_source_edge_sync.sv
// jtag_edge_sync: multi-flop synchronizer for one async level plus a
// registered rise/fall detector behind it.
module jtag_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;
    logic              w_lvl;

    assign w_lvl  = r_sync[STAGES-1];
    assign o_rise = r_rise;
    assign o_fall = r_fall;

    // Synchronize the input, then register one-cycle edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= w_lvl;
            r_rise <= w_lvl & ~r_prev;
            r_fall <= ~w_lvl & r_prev;
        end
    end

endmodule

// File: rtl/jtag_vio_source.sv
// jtag_vio_source: JTAG ER2 user-register to parallel probe word, with
// readback of the current probe value on TDO during every access.
module jtag_vio_source
    import jtag_vio_pkg::*;
#(
    parameter int               WIDTH       = 24,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock_dvi,
    input  logic             reset_n,
    input  logic             jtag_tck_i,
    input  logic             jtag_tdi_i,
    input  logic             jtag_enable_i,
    input  logic             jtag_shift_i,
    input  logic             jtag_update_i,
    output logic             jtag_tdo_o,
    output logic [WIDTH-1:0] probe_o,
    output logic             probe_strobe_o,
    output logic             length_err_o
);

    localparam int CW = vio_cnt_w(WIDTH);

    logic [SYNC_STAGES-1:0][2:0] r_lvl_sync;
    logic [WIDTH-1:0]            r_sr;
    logic [CW-1:0]               r_cnt;
    logic [WIDTH-1:0]            r_probe;
    logic                        r_strobe;
    logic                        r_err;
    logic                        r_tdo;
    vio_state_t                  r_state;

    logic w_tck_rise;
    logic w_tck_fall;
    logic w_upd_rise;
    logic w_upd_fall;
    logic w_tdi;
    logic w_en;
    logic w_shift;

    assign w_tdi   = r_lvl_sync[SYNC_STAGES-1][2];
    assign w_en    = r_lvl_sync[SYNC_STAGES-1][1];
    assign w_shift = r_lvl_sync[SYNC_STAGES-1][0];

    assign jtag_tdo_o     = r_tdo;
    assign probe_o        = r_probe;
    assign probe_strobe_o = r_strobe;
    assign length_err_o   = r_err;

    jtag_edge_sync #(.STAGES(SYNC_STAGES)) u_tck_sync (
        .clk    (clock_dvi),
        .rst_n  (reset_n),
        .i_d    (jtag_tck_i),
        .o_rise (w_tck_rise),
        .o_fall (w_tck_fall)
    );

    jtag_edge_sync #(.STAGES(SYNC_STAGES)) u_upd_sync (
        .clk    (clock_dvi),
        .rst_n  (reset_n),
        .i_d    (jtag_update_i),
        .o_rise (w_upd_rise),
        .o_fall (w_upd_fall)
    );

    // Level-only JTAG inputs: plain synchronizer chains, no edge logic.
    always_ff @(posedge clock_dvi or negedge reset_n) begin
        if (!reset_n) begin
            r_lvl_sync <= '0;
        end else begin
            r_lvl_sync <= {r_lvl_sync[SYNC_STAGES-2:0],
                           {jtag_tdi_i, jtag_enable_i, jtag_shift_i}};
        end
    end

    // Access FSM; update outranks a coincident TCK edge, which is dropped.
    always_ff @(posedge clock_dvi or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= VIO_IDLE;
            r_sr     <= '0;
            r_cnt    <= '0;
            r_probe  <= RESET_VALUE;
            r_strobe <= 1'b0;
            r_err    <= 1'b0;
            r_tdo    <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_tck_fall) begin
                r_tdo <= r_sr[0];
            end
            if (w_upd_rise && w_en) begin
                if (r_cnt == CW'(WIDTH)) begin
                    r_probe  <= r_sr;
                    r_strobe <= 1'b1;
                    r_err    <= 1'b0;
                end else begin
                    r_err <= 1'b1;
                end
                r_cnt   <= '0;
                r_state <= VIO_IDLE;
            end else if (!w_en) begin
                r_state <= VIO_IDLE;
            end else if (w_tck_rise) begin
                if (w_shift) begin
                    r_sr    <= {w_tdi, r_sr[WIDTH-1:1]};
                    r_state <= VIO_SHIFT;
                    if (r_cnt != CW'(WIDTH + 1)) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end else begin
                    r_sr    <= r_probe;
                    r_cnt   <= '0;
                    r_state <= VIO_CAPTURE;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_vio_source.sv
// tb_jtag_vio_source: directed JTAG write/readback sequences with a
// strobe scoreboard and a TDO readback queue checked at each TCK rise.
module tb_jtag_vio_source;

    localparam int          W   = 24;
    localparam int          S   = 2;
    localparam int          PH  = 5;
    localparam logic [23:0] RV  = 24'h123456;

    logic          clock_dvi;
    logic          reset_n;
    logic          jtag_tck_i;
    logic          jtag_tdi_i;
    logic          jtag_enable_i;
    logic          jtag_shift_i;
    logic          jtag_update_i;
    logic          jtag_tdo_o;
    logic [W-1:0]  probe_o;
    logic          probe_strobe_o;
    logic          length_err_o;

    int checks;
    int failures;
    int cyc;
    logic tdo_chk;

    typedef struct {
        logic [W-1:0] val;
        int           cyc;
    } strobe_exp_t;

    strobe_exp_t exp_q[$];
    logic        tdo_q[$];

    jtag_vio_source #(
        .WIDTH       (W),
        .SYNC_STAGES (S),
        .RESET_VALUE (RV)
    ) dut (
        .clock_dvi      (clock_dvi),
        .reset_n        (reset_n),
        .jtag_tck_i     (jtag_tck_i),
        .jtag_tdi_i     (jtag_tdi_i),
        .jtag_enable_i  (jtag_enable_i),
        .jtag_shift_i   (jtag_shift_i),
        .jtag_update_i  (jtag_update_i),
        .jtag_tdo_o     (jtag_tdo_o),
        .probe_o        (probe_o),
        .probe_strobe_o (probe_strobe_o),
        .length_err_o   (length_err_o)
    );

    initial clock_dvi = 1'b0;
    always #5 clock_dvi = ~clock_dvi;

    // Cycle counter used to time strobes against the raw update edge.
    always @(posedge clock_dvi) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe monitor: every strobe must match the oldest queued apply.
    always @(negedge clock_dvi) begin
        if (reset_n && probe_strobe_o) begin
            if (exp_q.size() == 0) begin
                checks = checks + 1;
                failures = failures + 1;
                $display("FAIL unexpected_strobe: got probe %0h expected none",
                         probe_o);
            end else begin
                strobe_exp_t e;
                e = exp_q.pop_front();
                check("strobe_value", 64'(probe_o), 64'(e.val));
                check("strobe_cycle", 64'(cyc), 64'(e.cyc + S + 2));
            end
        end
    end

    // TDO monitor: host samples readback on its own TCK rise.
    always @(posedge jtag_tck_i) begin
        if (tdo_chk) begin
            if (tdo_q.size() == 0) begin
                checks = checks + 1;
                failures = failures + 1;
                $display("FAIL tdo_underflow: got %0b expected none", jtag_tdo_o);
            end else begin
                logic b;
                b = tdo_q.pop_front();
                check("tdo_bit", 64'(jtag_tdo_o), 64'(b));
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock_dvi);
        #1;
    endtask

    task automatic tck_pulse(input logic tdi);
        jtag_tdi_i = tdi;
        wait_cyc(PH);
        jtag_tck_i = 1'b1;
        wait_cyc(PH);
        jtag_tck_i = 1'b0;
    endtask

    task automatic do_write(input logic [W-1:0] val, input int nbits,
                            input logic en, input logic cap,
                            input logic chk, input logic [W-1:0] tdo_exp,
                            input logic apply, input logic coinc);
        jtag_enable_i = en;
        wait_cyc(2);
        if (cap) begin
            jtag_shift_i = 1'b0;
            tck_pulse(1'b0);
        end
        jtag_shift_i = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            if (chk) tdo_q.push_back(tdo_exp[i]);
            tdo_chk = chk;
            tck_pulse(val[i]);
        end
        tdo_chk = 1'b0;
        if (!coinc) jtag_shift_i = 1'b0;
        wait_cyc(PH);
        jtag_update_i = 1'b1;
        if (coinc) begin
            jtag_tdi_i = 1'b1;
            jtag_tck_i = 1'b1;
        end
        if (apply) exp_q.push_back('{val: val, cyc: cyc});
        wait_cyc(PH);
        jtag_update_i = 1'b0;
        jtag_tck_i    = 1'b0;
        jtag_shift_i  = 1'b0;
        wait_cyc(PH);
        jtag_enable_i = 1'b0;
        wait_cyc(PH);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        tdo_chk = 1'b0;
        reset_n = 1'b0;
        jtag_tck_i = 1'b0;
        jtag_tdi_i = 1'b0;
        jtag_enable_i = 1'b0;
        jtag_shift_i = 1'b0;
        jtag_update_i = 1'b0;
        wait_cyc(3);
        check("reset_probe", 64'(probe_o), 64'(RV));
        check("reset_strobe", 64'(probe_strobe_o), 64'd0);
        check("reset_err", 64'(length_err_o), 64'd0);
        check("reset_tdo", 64'(jtag_tdo_o), 64'd0);
        reset_n = 1'b1;
        wait_cyc(3);

        do_write(24'hA5C3F0, 24, 1'b1, 1'b1, 1'b1, RV, 1'b1, 1'b0);
        check("write1_probe", 64'(probe_o), 64'hA5C3F0);
        check("write1_err", 64'(length_err_o), 64'd0);

        do_write(24'h0F0F0F, 23, 1'b1, 1'b1, 1'b1, 24'hA5C3F0, 1'b0, 1'b0);
        check("short_probe", 64'(probe_o), 64'hA5C3F0);
        check("short_err", 64'(length_err_o), 64'd1);

        do_write(24'h3C3C3C, 24, 1'b1, 1'b1, 1'b1, 24'hA5C3F0, 1'b1, 1'b0);
        check("recover_probe", 64'(probe_o), 64'h3C3C3C);
        check("recover_err", 64'(length_err_o), 64'd0);

        do_write(24'hFFFFFF, 24, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("disabled_probe", 64'(probe_o), 64'h3C3C3C);
        check("disabled_tdo", 64'(jtag_tdo_o), 64'd0);
        check("disabled_err", 64'(length_err_o), 64'd0);

        do_write(24'h5A5A5A, 24, 1'b1, 1'b0, 1'b1, 24'h3C3C3C, 1'b1, 1'b0);
        check("nocap_probe", 64'(probe_o), 64'h5A5A5A);

        do_write(24'h0F1E2D, 24, 1'b1, 1'b1, 1'b1, 24'h5A5A5A, 1'b1, 1'b1);
        check("coinc_probe", 64'(probe_o), 64'h0F1E2D);
        check("coinc_err", 64'(length_err_o), 64'd0);

        jtag_enable_i = 1'b1;
        wait_cyc(2);
        jtag_shift_i = 1'b0;
        tck_pulse(1'b0);
        jtag_shift_i = 1'b1;
        for (int i = 0; i < 10; i++) tck_pulse(1'b1);
        reset_n = 1'b0;
        wait_cyc(3);
        check("midrst_probe", 64'(probe_o), 64'(RV));
        check("midrst_tdo", 64'(jtag_tdo_o), 64'd0);
        check("midrst_strobe", 64'(probe_strobe_o), 64'd0);
        jtag_enable_i = 1'b0;
        jtag_shift_i = 1'b0;
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(3);

        do_write(24'h00FFFF, 24, 1'b1, 1'b1, 1'b1, RV, 1'b1, 1'b0);
        check("postrst_probe", 64'(probe_o), 64'h00FFFF);
        check("postrst_err", 64'(length_err_o), 64'd0);

        wait_cyc(10);
        check("strobe_queue_empty", 64'(exp_q.size()), 64'd0);
        check("tdo_queue_empty", 64'(tdo_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
